// File: rtl/ika2151_timer_pkg.sv
// Shared constants and helpers for the IKA2151 timer bank.
package ika2151_timer_pkg;

   // Slow mode advances a timer on one base tick out of every SLOW_DIV.
   localparam int SLOW_DIV = 16;
   localparam int DIV_W    = 4;

   // Number of bits needed to hold the values 0..value-1 (at least 1).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int b = 1; b < 31; b++) begin
         if (value > (1 << b)) begin
            r = b + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ika2151_timer_ch.sv
// One interval timer channel: up-counter with reload, overflow pulse and
// sticky IRQ flag. All state moves only on enabled clock edges.
module ika2151_timer_ch
   import ika2151_timer_pkg::*;
#(
   parameter int CNT_W = 10
) (
   input  logic             i_EMUCLK,
   input  logic             i_MRST,
   input  logic             i_en,
   input  logic             i_step,
   input  logic [CNT_W-1:0] i_load,
   input  logic             i_run,
   input  logic             i_irqen,
   input  logic             i_frst,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_ovfl,
   output logic             o_flag
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_ovfl;
   logic             r_flag;
   logic             w_full;
   logic             w_wrap;

   assign w_full = &r_cnt;
   // A wrap only counts while running; a stopped timer is held at LOAD so
   // a pulse that would coincide with RUN falling is dropped.
   assign w_wrap = i_run & i_step & w_full;

   // Counter and one-enabled-period overflow pulse.
   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         r_cnt  <= '0;
         r_ovfl <= 1'b0;
      end else if (i_en) begin
         if (!i_run) begin
            r_cnt  <= i_load;
            r_ovfl <= 1'b0;
         end else if (i_step) begin
            if (w_full) begin
               r_cnt  <= i_load;
               r_ovfl <= 1'b1;
            end else begin
               r_cnt  <= r_cnt + 1'b1;
               r_ovfl <= 1'b0;
            end
         end else begin
            r_ovfl <= 1'b0;
         end
      end
   end

   // Sticky flag: a coincident overflow beats the clear strobe.
   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         r_flag <= 1'b0;
      end else if (i_en) begin
         if (w_wrap && i_irqen) begin
            r_flag <= 1'b1;
         end else if (i_frst) begin
            r_flag <= 1'b0;
         end
      end
   end

   assign o_cnt  = r_cnt;
   assign o_ovfl = r_ovfl;
   assign o_flag = r_flag;

endmodule

// File: rtl/ika2151_timer_bank.sv
// Timer bank: shared phi1 prescaler and x16 slow divider feeding
// NUM_TIMERS independent channels, plus IRQ and CSM outputs.
module ika2151_timer_bank
   import ika2151_timer_pkg::*;
#(
   parameter int NUM_TIMERS = 2,
   parameter int CNT_W      = 10,
   parameter int PRESCALE   = 64
) (
   input  logic                        i_EMUCLK,
   input  logic                        i_MRST,
   input  logic                        i_phi1_NCEN_n,
   input  logic [NUM_TIMERS*CNT_W-1:0] i_LOAD,
   input  logic [NUM_TIMERS-1:0]       i_RUN,
   input  logic [NUM_TIMERS-1:0]       i_SLOW,
   input  logic [NUM_TIMERS-1:0]       i_IRQEN,
   input  logic [NUM_TIMERS-1:0]       i_FRST,
   output logic [NUM_TIMERS*CNT_W-1:0] o_CNT,
   output logic [NUM_TIMERS-1:0]       o_FLAG,
   output logic [NUM_TIMERS-1:0]       o_OVFL,
   output logic                        o_IRQ_n,
   output logic                        o_CSM
);

   localparam int PRE_W = clog2(PRESCALE);

   logic [PRE_W-1:0]      r_pre;
   logic [DIV_W-1:0]      r_div;
   logic                  w_en;
   logic                  w_pre_last;
   logic                  w_tk;
   logic                  w_stk;
   logic [NUM_TIMERS-1:0] w_step;

   assign w_en       = ~i_phi1_NCEN_n;
   assign w_pre_last = (r_pre == PRE_W'(PRESCALE - 1));
   // Base tick is combinational so it lines up with the enabled edge that
   // wraps the prescaler.
   assign w_tk       = w_en & w_pre_last;
   assign w_stk      = w_tk & (r_div == DIV_W'(SLOW_DIV - 1));

   // Free-running prescaler, independent of any RUN bit.
   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         r_pre <= '0;
      end else if (w_en) begin
         r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
      end
   end

   // Slow divider counts base ticks; natural 4-bit wrap gives the /16.
   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         r_div <= '0;
      end else if (w_tk) begin
         r_div <= r_div + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
         assign w_step[gi] = i_SLOW[gi] ? w_stk : w_tk;

         ika2151_timer_ch #(
            .CNT_W (CNT_W)
         ) u_ch (
            .i_EMUCLK (i_EMUCLK),
            .i_MRST   (i_MRST),
            .i_en     (w_en),
            .i_step   (w_step[gi]),
            .i_load   (i_LOAD[gi*CNT_W +: CNT_W]),
            .i_run    (i_RUN[gi]),
            .i_irqen  (i_IRQEN[gi]),
            .i_frst   (i_FRST[gi]),
            .o_cnt    (o_CNT[gi*CNT_W +: CNT_W]),
            .o_ovfl   (o_OVFL[gi]),
            .o_flag   (o_FLAG[gi])
         );
      end
   endgenerate

   assign o_IRQ_n = ~|o_FLAG;
   assign o_CSM   = o_OVFL[0];

endmodule

// File: tb/tb_ika2151_timer_bank.sv
// Bench for ika2151_timer_bank: a step-count model checked every cycle,
// plus directed scenarios with hand-computed periods and widths.
module tb_ika2151_timer_bank;

   localparam int N = 2;
   localparam int W = 10;
   localparam int P = 64;

   logic           clk   = 1'b0;
   logic           rst   = 1'b0;
   logic           ncen  = 1'b0;
   logic           mode4 = 1'b0;
   logic [N*W-1:0] load  = '0;
   logic [N-1:0]   run   = '0;
   logic [N-1:0]   slow  = '0;
   logic [N-1:0]   irqen = '0;
   logic [N-1:0]   frst  = '0;
   logic [N*W-1:0] cnt;
   logic [N-1:0]   flag;
   logic [N-1:0]   ovfl;
   logic           irq_n;
   logic           csm;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ika2151_timer_bank #(
      .NUM_TIMERS (N),
      .CNT_W      (W),
      .PRESCALE   (P)
   ) dut (
      .i_EMUCLK      (clk),
      .i_MRST        (rst),
      .i_phi1_NCEN_n (ncen),
      .i_LOAD        (load),
      .i_RUN         (run),
      .i_SLOW        (slow),
      .i_IRQEN       (irqen),
      .i_FRST        (frst),
      .o_CNT         (cnt),
      .o_FLAG        (flag),
      .o_OVFL        (ovfl),
      .o_IRQ_n       (irq_n),
      .o_CSM         (csm)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: count enabled edges and base ticks since reset; each timer is
   // tracked as "steps left until overflow" (1 means the next step wraps).
   int m_edges;
   int m_ticks;
   int m_rem  [N];
   bit m_ovfl [N];
   bit m_flag [N];

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_edges = 0;
            m_ticks = 0;
            for (int i = 0; i < N; i++) begin
               m_rem[i]  = 1 << W;
               m_ovfl[i] = 1'b0;
               m_flag[i] = 1'b0;
            end
         end else if (!ncen) begin
            bit tick;
            bit stick;
            tick  = (m_edges % P) == P - 1;
            stick = tick && ((m_ticks % 16) == 15);
            m_edges++;
            if (tick) m_ticks++;
            for (int i = 0; i < N; i++) begin
               bit st;
               bit ov;
               int ld;
               ld = int'(load[i*W +: W]);
               st = slow[i] ? stick : tick;
               ov = 1'b0;
               if (!run[i]) begin
                  m_rem[i] = (1 << W) - ld;
               end else if (st) begin
                  if (m_rem[i] == 1) begin
                     ov       = 1'b1;
                     m_rem[i] = (1 << W) - ld;
                  end else begin
                     m_rem[i] = m_rem[i] - 1;
                  end
               end
               m_ovfl[i] = ov;
               if (ov && irqen[i]) m_flag[i] = 1'b1;
               else if (frst[i]) m_flag[i] = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         logic [N*W-1:0] e_cnt;
         logic [N-1:0]   e_ovfl;
         logic [N-1:0]   e_flag;
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            e_cnt[i*W +: W] = W'((1 << W) - m_rem[i]);
            e_ovfl[i]       = m_ovfl[i];
            e_flag[i]       = m_flag[i];
         end
         check("model_cnt",   longint'(cnt),   longint'(e_cnt));
         check("model_ovfl",  longint'(ovfl),  longint'(e_ovfl));
         check("model_flag",  longint'(flag),  longint'(e_flag));
         check("model_irq_n", longint'(irq_n), longint'(~|e_flag));
         check("model_csm",   longint'(csm),   longint'(e_ovfl[0]));
      end
   end

   // Clock-enable pattern: every cycle, or one cycle in four.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         ph++;
         ncen = mode4 ? ((ph % 4) != 0) : 1'b0;
      end
   end

   // Wait for a rising edge of OVFL[idx]; t is the cycle index where seen.
   task automatic wait_pulse(input int idx, input int limit, output int t);
      bit prev;
      bit seen;
      prev = ovfl[idx];
      seen = 1'b0;
      t    = -1;
      for (int n = 0; n < limit && !seen; n++) begin
         @(negedge clk);
         if (ovfl[idx] && !prev) begin
            seen = 1'b1;
            t    = int'($time / 10);
         end
         prev = ovfl[idx];
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL pulse_timeout timer=%0d actual=none required=pulse within %0d cycles", idx, limit);
      end
   endtask

   initial begin
      int t0, t1, w, np, guard;

      // Reset state.
      #1 rst = 1'b1;
      #1;
      check("rst_cnt",   longint'(cnt),   0);
      check("rst_flag",  longint'(flag),  0);
      check("rst_ovfl",  longint'(ovfl),  0);
      check("rst_irq_n", longint'(irq_n), 1);
      check("rst_csm",   longint'(csm),   0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Timer 0 overflows every step (64 cycles); timer 1 slow, flag masked.
      load  = {10'd1022, 10'd1023};
      irqen = 2'b01;
      slow  = 2'b10;
      @(negedge clk);
      run = 2'b11;
      wait_pulse(0, 200, t0);
      check("flag0_after_first", longint'(flag[0]), 1);
      check("irq_n_after_first", longint'(irq_n),   0);
      check("csm_pulse",         longint'(csm),     1);
      wait_pulse(0, 200, t1);
      check("period_1023_a", t1 - t0, 64);
      t0 = t1;
      wait_pulse(0, 200, t1);
      check("period_1023_b", t1 - t0, 64);

      // Clear strobe on the overflow edge loses; one edge later it clears.
      repeat (63) @(negedge clk);
      frst[0] = 1'b1;
      @(negedge clk);
      t0 = int'($time / 10);
      check("frst_same_edge_ovfl", longint'(ovfl[0]), 1);
      check("frst_same_edge_flag", longint'(flag[0]), 1);
      @(negedge clk);
      check("frst_later_flag",  longint'(flag[0]), 0);
      check("frst_later_irq_n", longint'(irq_n),   1);
      frst[0] = 1'b0;

      // New LOAD only applies at the next reload.
      load[0 +: W] = 10'd1020;
      wait_pulse(0, 200, t1);
      check("load_change_pending", t1 - t0, 64);
      t0 = t1;
      wait_pulse(0, 400, t1);
      check("period_1020", t1 - t0, 256);
      t0 = t1;
      repeat (100) @(negedge clk);
      load[0 +: W] = 10'd1022;
      wait_pulse(0, 400, t1);
      check("mid_change_finish", t1 - t0, 256);
      t0 = t1;
      wait_pulse(0, 400, t1);
      check("period_1022_a", t1 - t0, 128);
      t0 = t1;
      wait_pulse(0, 400, t1);
      check("period_1022_b", t1 - t0, 128);

      // Slow timer 1: 2 steps x 16 ticks x 64 cycles; IRQEN1 = 0.
      wait_pulse(1, 2600, t0);
      check("slow_ovfl1",  longint'(ovfl[1]), 1);
      check("slow_flag1",  longint'(flag[1]), 0);
      wait_pulse(1, 2600, t1);
      check("slow_period", t1 - t0, 2048);

      // Enable one cycle in four: width 4 cycles, period x4.
      load[0 +: W] = 10'd1023;
      mode4 = 1'b1;
      wait_pulse(0, 1500, t0);
      wait_pulse(0, 1500, t0);
      w = 1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ovfl[0]) w++;
         else break;
      end
      check("ovfl_width_en4", w, 4);
      wait_pulse(0, 1500, t1);
      check("period_en4", t1 - t0, 256);
      mode4 = 1'b0;

      // Reset in the middle of a count.
      load[0 +: W] = 10'd990;
      @(negedge clk);
      run[0] = 1'b0;
      @(negedge clk);
      run[0] = 1'b1;
      guard = 0;
      while (cnt[0 +: W] != 10'd1000 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("reach_1000", longint'(cnt[0 +: W]), 1000);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_cnt",   longint'(cnt),   0);
      check("mid_rst_flag",  longint'(flag),  0);
      check("mid_rst_ovfl",  longint'(ovfl),  0);
      check("mid_rst_irq_n", longint'(irq_n), 1);
      check("mid_rst_csm",   longint'(csm),   0);
      run = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      np = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (ovfl != '0) np++;
      end
      check("no_pulse_after_rst", np, 0);
      check("stopped_cnt0", longint'(cnt[0 +: W]), 990);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ika2151_timer_bank.md
# ika2151_timer_bank

Parametrised timer bank for the IKA2151 core: N independent up-counting interval timers sharing one phi1-derived prescaler, each with its own reload value, run control, optional ×16 slow mode, sticky overflow flag and IRQ enable. It is the generalised successor to the fixed two-timer (A/B) unit. It drives the register block's TIMERA_FLAG / TIMERB_FLAG / TIMERA_OVFL inputs, and timer 0's overflow pulse serves as the CSM key-on trigger.

## Interface
- NUM_TIMERS, 2: number of timer channels (1..8).
- CNT_W, 10: counter and reload width in bits (2..16).
- PRESCALE, 64: enabled phi1 cycles per base tick (2..256).
- i_EMUCLK  in  1  emulator master clock; all flops on posedge.
- i_MRST  in  1  asynchronous, active-high reset.
- i_phi1_NCEN_n  in  1  active-low clock enable. State advances only on edges where it is 0.
- i_LOAD  in  NUM_TIMERS*CNT_W  reload values, timer i at [i*CNT_W +: CNT_W].
- i_RUN  in  NUM_TIMERS  per-timer run enable.
- i_SLOW  in  NUM_TIMERS  1 = timer advances on every 16th base tick.
- i_IRQEN  in  NUM_TIMERS  1 = overflow sets the flag.
- i_FRST  in  NUM_TIMERS  flag-clear strobe, sampled on enabled edges.
- o_CNT  out  NUM_TIMERS*CNT_W  current counter values, for debug.
- o_FLAG  out  NUM_TIMERS  sticky overflow flags.
- o_OVFL  out  NUM_TIMERS  one-enabled-cycle overflow pulse, independent of IRQEN.
- o_IRQ_n  out  1  active-low; equals ~|o_FLAG.
- o_CSM  out  1  equals o_OVFL[0].

## Operation
- Prescaler (PRE_W = clog2(PRESCALE)):
  - counts 0..PRESCALE-1 on enabled edges and wraps;
  - base tick `tk` is high combinationally while the prescaler equals PRESCALE-1 and i_phi1_NCEN_n = 0.
- Slow divider:
  - shared 4-bit counter, increments on `tk`;
  - `stk` = tk & (div == 15).
- Per timer i: step_i = i_SLOW[i] ? stk : tk. On each enabled edge:
  - RUN = 0: CNT ← LOAD, OVFL ← 0. The counter stays loaded, so the value is always fresh at start.
  - RUN = 1 and step_i = 1 and CNT = all-ones: CNT ← LOAD, OVFL ← 1, and FLAG ← 1 if IRQEN.
  - RUN = 1 and step_i = 1 otherwise: CNT ← CNT+1, OVFL ← 0.
  - RUN = 1 and step_i = 0: CNT holds, OVFL ← 0.
- Overflow period: (2^CNT_W − LOAD) steps. LOAD = all-ones gives an overflow every step.
- Flag:
  - i_FRST[i] on an enabled edge clears FLAG[i];
  - simultaneous set and clear: set wins;
  - clearing IRQEN does not clear an already-set flag.
- Changing LOAD while running takes effect at the next reload only.
- Prescaler and slow divider free-run regardless of RUN, so the start phase is not aligned to RUN.

## Timing
- Reset values, asynchronous and immediate:
  - prescaler = 0, divider = 0, all CNT = 0;
  - FLAG = 0, OVFL = 0;
  - o_IRQ_n = 1, o_CSM = 0.
- After reset release, with RUN = 1 the first enabled edge loads nothing. The counter starts from 0 unless RUN was low for at least one enabled edge. RUN is normally low out of reset (register defaults).
- OVFL and FLAG are registered and both rise on the same enabled edge as the reload. OVFL stays high for exactly one enabled period; EMUCLK cycles between enables do not shorten it.
- o_IRQ_n is combinational from FLAG, so no extra latency.
- RUN 0→1: counting begins at the next step. RUN 1→0: the next enabled edge reloads; a pulse pending on that edge is suppressed.
- i_MRST mid-count aborts everything; no overflow pulse is emitted.

## Structure
- Package ika2151_timer_pkg:
  - localparams SLOW_DIV = 16 and DIV_W = 4;
  - function clog2 for PRE_W.
- Sub-module ika2151_timer_ch:
  - one counter, its flag and its pulse;
  - ports: clock, reset, enable, step, load, run, irqen, frst;
  - generated NUM_TIMERS times.
- Top level holds the prescaler, the slow divider and the IRQ/CSM reduction.

## Test plan
- Defaults, enable every cycle, LOAD0 = 1023, RUN0 = 1, IRQEN0 = 1 -> OVFL0/CSM pulse every 64 cycles; FLAG0 and IRQ_n = 0 after the first.
- LOAD0 = 1020 -> overflow period 256 cycles. Change LOAD0 to 1022 mid-count -> the current period finishes at 256, then every 128.
- Timer 1, SLOW = 1, LOAD1 = 1022 -> overflow every 2×16×64 = 2048 cycles; IRQEN1 = 0 -> OVFL1 pulses, FLAG1 stays 0.
- FRST0 asserted on the same enabled edge as overflow -> FLAG0 = 1. FRST0 one edge later -> FLAG0 = 0, IRQ_n = 1.
- Enable every 4th cycle -> OVFL width is 4 EMUCLK cycles; period scales ×4.
- Assert i_MRST mid-count with CNT = 1000 -> all outputs take reset values asynchronously; no pulse after release while RUN = 0.
